// File: rtl/nxn_trace_grid.sv
// rtl/nxn_trace_grid.sv - N x N IR trace grid with per-pixel box colouring and clear hold
module nxn_trace_grid #(
  parameter int GRID_N     = 4,
  parameter int BOX_PX     = 100,
  parameter int ORIGIN_ROW = 40,
  parameter int ORIGIN_COL = 120,
  parameter int CLEAR_HOLD = 10000000,
  parameter int BROOM_BOX  = 6,
  localparam int N2 = GRID_N * GRID_N,
  localparam int CW = $clog2(N2 + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [8:0]    row,
  input  logic [9:0]    col,
  input  logic [N2-1:0] ir_in,
  input  logic [1:0]    house,
  input  logic          house_valid,
  input  logic          broom_powerup,
  input  logic          two_player_mode,
  input  logic          clear_my_trace,
  input  logic          reset_trace,
  input  logic [N2-1:0] snitch_location,
  input  logic [N2-1:0] displayed_trace,
  output logic [N2-1:0] already_traced,
  output logic          color_in_box,
  output logic [7:0]    box_color,
  output logic          reset_other_player_trace,
  output logic [CW-1:0] hit_count,
  output logic [CW-1:0] miss_count,
  output logic          clearing
);

  localparam int HW = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(CLEAR_HOLD - 1);

  typedef enum logic {TRACK, CLEAR} state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic            broom_q;
  logic [GRID_N-1:0] row_hit, col_hit;
  logic [N2-1:0]   box_hit;
  logic            sel_traced, sel_snitch, sel_disp;
  logic            broom_cond, local_clear, pix_ok;
  logic [7:0]      color_nxt;
  logic [CW-1:0]   hit_n, miss_n;

  // Box decode by constant range compares per band; a pixel lands in at most one box.
  always_comb begin
    row_hit = '0;
    col_hit = '0;
    box_hit = '0;
    for (int r = 0; r < GRID_N; r++) begin
      row_hit[r] = (int'(row) >= ORIGIN_ROW + r * BOX_PX) && (int'(row) < ORIGIN_ROW + (r + 1) * BOX_PX);
      col_hit[r] = (int'(col) >= ORIGIN_COL + r * BOX_PX) && (int'(col) < ORIGIN_COL + (r + 1) * BOX_PX);
    end
    for (int r = 0; r < GRID_N; r++)
      for (int c = 0; c < GRID_N; c++)
        box_hit[r * GRID_N + c] = row_hit[r] & col_hit[c];
  end

  assign sel_traced  = |(box_hit & already_traced);
  assign sel_snitch  = |(box_hit & snitch_location);
  assign sel_disp    = |(box_hit & displayed_trace);
  assign broom_cond  = two_player_mode & broom_powerup & ir_in[BROOM_BOX];
  assign local_clear = two_player_mode ? clear_my_trace : (broom_powerup & ir_in[BROOM_BOX]);
  assign pix_ok      = (state == TRACK) && !reset_trace;

  always_comb begin
    color_nxt = 8'h00;
    if (sel_traced) begin
      if (sel_snitch)
        color_nxt = 8'h50;
      else if (house_valid) begin
        case (house)
          2'd0:    color_nxt = sel_disp ? 8'h49 : 8'h4A;
          2'd1:    color_nxt = sel_disp ? 8'hDC : 8'hDD;
          2'd2:    color_nxt = sel_disp ? 8'h16 : 8'h17;
          default: color_nxt = sel_disp ? 8'h9A : 8'h99;
        endcase
      end
    end
  end

  always_comb begin
    hit_n  = '0;
    miss_n = '0;
    for (int i = 0; i < N2; i++) begin
      hit_n  = hit_n  + CW'(already_traced[i] & displayed_trace[i]);
      miss_n = miss_n + CW'(already_traced[i] & ~displayed_trace[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_in_box <= 1'b0;
      box_color    <= 8'h00;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      color_in_box <= pix_ok & sel_traced;
      box_color    <= pix_ok ? color_nxt : 8'h00;
      hit_count    <= hit_n;
      miss_count   <= miss_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                    <= TRACK;
      hold_cnt                 <= '0;
      already_traced           <= '0;
      clearing                 <= 1'b0;
      broom_q                  <= 1'b0;
      reset_other_player_trace <= 1'b0;
    end else begin
      broom_q                  <= broom_cond;
      reset_other_player_trace <= broom_cond & ~broom_q;
      case (state)
        TRACK: begin
          if (reset_trace) begin
            state          <= CLEAR;
            clearing       <= 1'b1;
            hold_cnt       <= '0;
            already_traced <= '0;
          end else if (local_clear)
            already_traced <= '0;
          else
            already_traced <= already_traced | ir_in;
        end
        default: begin
          already_traced <= '0;
          // A fresh reset_trace restarts the full hold from zero.
          if (reset_trace)
            hold_cnt <= '0;
          else if (hold_cnt == HOLD_LAST) begin
            state    <= TRACK;
            clearing <= 1'b0;
            hold_cnt <= '0;
          end else
            hold_cnt <= hold_cnt + 1'b1;
        end
      endcase
    end
  end

endmodule
